// File: rtl/modport_device.sv
`default_nettype none
// ============================================================================
// Module   : modport_device
// Purpose  : Wishbone B4 classic single-transfer register target. A bank of
//            NUM_REGS registers, each DAT_WIDTH bits, answered with a
//            registered ack/err/rty pulse after WAIT_STATES idle cycles.
//            Out-of-range addresses end in err; writes while lock is high
//            end in rty.
// Ports    : clk_i    - clock (rising edge)
//            rst_ni   - asynchronous active-low reset
//            cyc_i    - bus cycle in progress
//            stb_i    - strobe
//            we_i     - 1 = write, 0 = read
//            adr_i    - word address
//            dat_i    - write data
//            dat_o    - read data (zero outside a read ack)
//            ack_o    - normal termination
//            err_o    - error termination
//            rty_o    - retry termination
//            lock_i   - refuse writes with retry while high
//            regs_o   - flattened register contents, reg k at [k*DAT_WIDTH +: DAT_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module modport_device #(
    parameter int DAT_WIDTH   = 8,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cyc_i,
    input  logic                            stb_i,
    input  logic                            we_i,
    input  logic [ADDR_WIDTH-1:0]           adr_i,
    input  logic [DAT_WIDTH-1:0]            dat_i,
    output logic [DAT_WIDTH-1:0]            dat_o,
    output logic                            ack_o,
    output logic                            err_o,
    output logic                            rty_o,
    input  logic                            lock_i,
    output logic [NUM_REGS*DAT_WIDTH-1:0]   regs_o
);

    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    resp_fire;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    we_q;
    logic [DAT_WIDTH-1:0]    dat_q;
    logic [DAT_WIDTH-1:0]    regs_q [NUM_REGS];

    logic                    req;
    logic [ADDR_WIDTH-1:0]   sel_adr;
    logic                    sel_we;
    logic [DAT_WIDTH-1:0]    sel_dat;
    logic                    is_err;
    logic                    is_rty;
    logic                    is_ack;
    logic [DAT_WIDTH-1:0]    rd_data;

    assign req = cyc_i && stb_i;

    // With zero wait states the response is registered on the same edge that
    // would capture the request, so the live bus fields are used directly.
    // In every other case the captured copy is authoritative.
    assign sel_adr = (state_q == ST_IDLE) ? adr_i : adr_q;
    assign sel_we  = (state_q == ST_IDLE) ? we_i  : we_q;
    assign sel_dat = (state_q == ST_IDLE) ? dat_i : dat_q;

    assign is_err = (32'(sel_adr) >= NUM_REGS_W);
    assign is_rty = !is_err && sel_we && lock_i;
    assign is_ack = !is_err && !is_rty;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_adr == ADDR_WIDTH'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state; resp_fire marks the edge that enters RESP
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        resp_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_RESP;
                        resp_fire = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping cyc_i in any wait cycle, including the last one,
                // abandons the transfer without a response.
                if (!cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    resp_fire = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adr_q <= '0;
            we_q  <= 1'b0;
            dat_q <= '0;
            cnt_q <= 4'd0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                adr_q <= adr_i;
                we_q  <= we_i;
                dat_q <= dat_i;
                cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs: single-cycle pulses, dat_o only during a read ack
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            rty_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            rty_o <= 1'b0;
            dat_o <= '0;
            if (resp_fire) begin
                ack_o <= is_ack;
                err_o <= is_err;
                rty_o <= is_rty;
                if (is_ack && !sel_we) begin
                    dat_o <= rd_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank: a write commits on the edge that raises ack_o
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (resp_fire && is_ack && sel_we) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (sel_adr == ADDR_WIDTH'(k)) begin
                    regs_q[k] <= sel_dat;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_o[g*DAT_WIDTH +: DAT_WIDTH] = regs_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_modport_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_modport_device
// Purpose  : Directed self-checking bench for modport_device. Three instances
//            (0, 3 and 2 wait states) share the bus fields; each has its own
//            cyc line so only the addressed instance sees a request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modport_device;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        stb, we, lock;
    logic [3:0]  adr;
    logic [7:0]  dat;
    logic        cyc0, cyc3, cyc2;

    logic [7:0]  dat_o0, dat_o3, dat_o2;
    logic        ack0, err0, rty0;
    logic        ack3, err3, rty3;
    logic        ack2, err2, rty2;
    logic [31:0] regs0, regs3, regs2;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    modport_device #(.DAT_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(4), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc0), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .dat_o(dat_o0), .ack_o(ack0), .err_o(err0),
        .rty_o(rty0), .lock_i(lock), .regs_o(regs0)
    );

    modport_device #(.DAT_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(4), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc3), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .dat_o(dat_o3), .ack_o(ack3), .err_o(err3),
        .rty_o(rty3), .lock_i(lock), .regs_o(regs3)
    );

    modport_device #(.DAT_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(4), .WAIT_STATES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n && rst2_n), .cyc_i(cyc2), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .dat_o(dat_o2), .ack_o(ack2), .err_o(err2),
        .rty_o(rty2), .lock_i(lock), .regs_o(regs2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; observe just after the rising edge settles.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cyc0 = 1'b0; cyc3 = 1'b0; cyc2 = 1'b0;
        stb  = 1'b0; we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b1; lock = 1'b0;
        adr = 4'd0; dat = 8'd0;
        idle_bus();
        tick(); tick();

        // Reset state
        check("rst_ack0",  {29'd0, ack0, err0, rty0}, 32'd0);
        check("rst_dat0",  32'(dat_o0), 32'd0);
        check("rst_regs0", regs0, 32'd0);
        check("rst_regs3", regs3, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- WAIT_STATES = 0 ----------------
        // Write adr 2 = A5: ack one cycle after the request
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd2; dat = 8'hA5;
        check("w2_noack_same_cycle", 32'(ack0), 32'd0);
        tick();
        check("w2_ack",   {29'd0, ack0, err0, rty0}, 32'b100);
        check("w2_reg2",  32'(regs0[23:16]), 32'hA5);
        idle_bus();
        tick();
        check("w2_ack_low_after", 32'(ack0), 32'd0);

        // Read adr 2
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2;
        tick();
        check("r2_ack", 32'(ack0), 32'd1);
        check("r2_dat", 32'(dat_o0), 32'hA5);
        idle_bus();
        tick();
        check("r2_dat_zero_after", 32'(dat_o0), 32'd0);

        // Out-of-range read
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd7;
        tick();
        check("r7_resp", {29'd0, ack0, err0, rty0}, 32'b010);
        check("r7_dat",  32'(dat_o0), 32'd0);
        idle_bus();
        tick();
        check("r7_err_low_after", 32'(err0), 32'd0);

        // Out-of-range write
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd7; dat = 8'hFF;
        tick();
        check("w7_resp", {29'd0, ack0, err0, rty0}, 32'b010);
        check("w7_regs", regs0, 32'h00A5_0000);
        idle_bus();
        tick();

        // Locked write is retried, register unchanged
        lock = 1'b1;
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd1; dat = 8'h3C;
        tick();
        check("lockw_resp", {29'd0, ack0, err0, rty0}, 32'b001);
        check("lockw_reg1", 32'(regs0[15:8]), 32'h00);
        idle_bus();
        tick();
        // Locked read still acks
        cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd1;
        tick();
        check("lockr_resp", {29'd0, ack0, err0, rty0}, 32'b100);
        check("lockr_dat",  32'(dat_o0), 32'h00);
        idle_bus();
        lock = 1'b0;
        tick();

        // Back-to-back writes with the request held: acks on cycles 1, 3, 5
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd0; dat = 8'h11;
        tick();
        check("b2b_c1_ack", 32'(ack0), 32'd1);
        adr = 4'd1; dat = 8'h22;
        tick();
        check("b2b_c2_ack", 32'(ack0), 32'd0);
        tick();
        check("b2b_c3_ack", 32'(ack0), 32'd1);
        adr = 4'd2; dat = 8'h33;
        tick();
        check("b2b_c4_ack", 32'(ack0), 32'd0);
        tick();
        check("b2b_c5_ack", 32'(ack0), 32'd1);
        check("b2b_regs",   regs0, 32'h0033_2211);
        idle_bus();
        tick();
        check("b2b_ack_low_after", 32'(ack0), 32'd0);

        // ---------------- WAIT_STATES = 3 ----------------
        cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd0; dat = 8'h5A;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ws3_w_early_c%0d", i), 32'(ack3), 32'd0);
        end
        tick();
        check("ws3_w_ack",  32'(ack3), 32'd1);
        check("ws3_w_regs", regs3, 32'h0000_005A);
        idle_bus();
        tick();

        cyc3 = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ws3_r_early_c%0d", i), 32'(ack3), 32'd0);
        end
        tick();
        check("ws3_r_ack", 32'(ack3), 32'd1);
        check("ws3_r_dat", 32'(dat_o3), 32'h5A);
        idle_bus();
        tick();
        check("ws3_r_dat_after", 32'(dat_o3), 32'd0);

        // ---------------- WAIT_STATES = 2 ----------------
        // Normal write to reg 3: ack on cycle 3
        cyc2 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd3; dat = 8'h42;
        tick(); tick();
        check("ws2_w_early", 32'(ack2), 32'd0);
        tick();
        check("ws2_w_ack",  32'(ack2), 32'd1);
        check("ws2_w_regs", regs2, 32'h4200_0000);
        idle_bus();
        tick();

        // Abort: drop cyc one cycle after the request
        cyc2 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd0; dat = 8'h77;
        tick();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_resp_c%0d", i), {29'd0, ack2, err2, rty2}, 32'd0);
        end
        check("abort_regs", regs2, 32'h4200_0000);

        // Reset while in WAIT: everything clears immediately, no commit
        cyc2 = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd1; dat = 8'h99;
        tick();
        rst2_n = 1'b0;
        #1;
        check("rst_wait_regs", regs2, 32'd0);
        check("rst_wait_resp", {21'd0, ack2, err2, rty2, dat_o2}, 32'd0);
        tick(); tick();
        idle_bus();
        rst2_n = 1'b1;
        tick(); tick();
        check("rst_after_resp", {29'd0, ack2, err2, rty2}, 32'd0);
        check("rst_after_regs", regs2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modport_device.md
# modport_device

Wishbone B4 classic single-read/write device: a bank of `NUM_REGS` registers, each `DAT_WIDTH` bits wide, behind the device side of the team's `wishbone_classic` interface. Acks are registered and inserted after a configurable number of wait states. Out-of-range accesses terminate with `err`, and writes during lock terminate with `rty`. The block sits on the system bus as a generic peripheral register target.

## Interface
- `DAT_WIDTH`, 8, data bus and register width.
- `NUM_REGS`, 4, number of registers (≥1).
- `ADDR_WIDTH`, 4, word-address width; addresses ≥ `NUM_REGS` are out of range.
- `WAIT_STATES`, 0, extra idle cycles inserted before the response (0–15).

Ports:
- `clk_i` in 1: the single clock; all logic is on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `cyc_i` in 1: bus cycle in progress.
- `stb_i` in 1: strobe.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in `ADDR_WIDTH`: word address.
- `dat_i` in `DAT_WIDTH`: write data.
- `dat_o` out `DAT_WIDTH`: read data.
- `ack_o` out 1: normal termination.
- `err_o` out 1: error termination.
- `rty_o` out 1: retry termination.
- `lock_i` in 1: when high, writes are refused with retry.
- `regs_o` out `NUM_REGS*DAT_WIDTH`: flattened register contents; register k is at bits [k*DAT_WIDTH +: DAT_WIDTH].

## Operation
- A request is `cyc_i && stb_i`.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a request, capture `adr_i`, `we_i` and `dat_i`.
  - If `WAIT_STATES`=0, go to RESP; otherwise load the counter with `WAIT_STATES` and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - If `cyc_i` drops, abort and return to IDLE. An aborted transfer has no response and no register change.
- RESP:
  - Assert exactly one of `ack_o`, `err_o`, `rty_o` for exactly one cycle, then return to IDLE unconditionally.
  - If `cyc_i` fell during the final WAIT cycle, abort instead (the RESP registration is gated by `cyc_i`).
- Response selection, in priority order:
  - captured address ≥ `NUM_REGS` → `err_o`;
  - write while `lock_i` is high (sampled on the edge entering RESP) → `rty_o`;
  - otherwise → `ack_o`.
- Write with ack: the register at the captured address takes the captured data on the same edge that raises `ack_o`, so `regs_o` shows the new value during the ack cycle.
- Read with ack: `dat_o` is loaded with the register value on the edge that raises `ack_o`.
- `dat_o` is 0 whenever `ack_o` is low, and 0 for reads that end in error.
- Back-to-back transfers: if the controller holds the request in the cycle after a response, that cycle is seen in IDLE as a new request and is captured normally.
- Response outputs are never asserted without a request having been captured first.

## Timing
- Reset (async assert, sync release): state IDLE; `ack_o`, `err_o`, `rty_o` = 0; `dat_o` = 0; all registers = 0; counter = 0.
- Reset mid-transfer: the transfer is abandoned, there is no response, and no write commits.
- Latency: a response is asserted 1+`WAIT_STATES` cycles after the cycle in which the request was first seen. There is never a combinational ack.
- Each response is a single-cycle pulse; all response outputs are low in the cycle that follows.
- Back-to-back throughput with `WAIT_STATES`=0: one transfer every 2 cycles.
- Request fields are sampled only at capture, in IDLE. The device relies on the controller keeping them stable until the response.

## Test plan
- Write then read, `WAIT_STATES`=0:
  - write `adr`=2, `dat`=0xA5 → `ack_o` one cycle after the request; `regs_o[23:16]`=0xA5 during ack.
  - read `adr`=2 → `ack_o` with `dat_o`=0xA5; `dat_o`=0 in the next cycle.
- `WAIT_STATES`=3, read `adr`=0 → ack exactly 4 cycles after the request; `ack_o` low in all earlier cycles.
- Out-of-range: read or write at `adr`=7 with `NUM_REGS`=4 → `err_o` pulse; no register changes; `dat_o`=0.
- Locked write: `lock_i`=1, write 0x3C to `adr`=1 → `rty_o` pulse; register 1 unchanged. A read of `adr`=1 under lock → `ack_o`.
- Back-to-back: hold the request through 3 writes to `adr`=0,1,2 → ack on cycles 1, 3, 5; all three registers updated.
- Abort and reset, `WAIT_STATES`=2:
  - drop `cyc_i` one cycle after the request → no response and no write.
  - assert `rst_ni`=0 while in WAIT → all outputs 0 immediately.
